ram_arbiter: RTL and testbench

- Shares the CPU's single-port synchronous RAM between three requesters: instruction fetch (PC side), data load/store (execute side) and an external program loader (bench/debug path).
- Sits between the cpu datapath and the RAM instance.
- Serialises accesses through a small FSM with req/ack handshakes, so fetch and data traffic never collide on the RAM port.
- Lets a loader write programs without poking RAM directly.

---
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter.sv | 91 +++++++++
 tb/tb_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester, RAM and status signals shared by the RAM arbiter and its users
//   loader: ld_req/ld_we/ld_addr/ld_wdata in, ld_ack/ld_rdata out
//   data:   dt_req/dt_we/dt_addr/dt_wdata in, dt_ack/dt_rdata out
//   fetch:  if_req/if_addr in, if_ack/if_rdata out
//   RAM:    ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in
//   status: busy (access in flight), owner (0 none, 1 fetch, 2 data, 3 loader)
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic ld_req, ld_we, ld_ack;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata, ld_rdata;
  logic dt_req, dt_we, dt_ack;
  logic [ADDR_W-1:0] dt_addr;
  logic [DATA_W-1:0] dt_wdata, dt_rdata;
  logic if_req, if_ack;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic busy;
  logic [1:0] owner;
  modport slave (
    input ld_req, ld_we, ld_addr, ld_wdata, dt_req, dt_we, dt_addr, dt_wdata,
          if_req, if_addr, ram_rdata,
    output ld_ack, ld_rdata, dt_ack, dt_rdata, if_ack, if_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy, owner
  );
  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, dt_req, dt_we, dt_addr, dt_wdata,
           if_req, if_addr, ram_rdata,
    input ld_ack, ld_rdata, dt_ack, dt_rdata, if_ack, if_rdata,
          ram_en, ram_we, ram_addr, ram_wdata, busy, owner
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises loader, data and fetch accesses onto one single-port synchronous RAM
//   clk, reset (sync, active high); bus: ram_arbiter_if.slave carrying all requester/RAM/status signals
//   Every access is IDLE (arbitrate) -> ISSUE (ram_en) -> RESP (capture); the ack is visible in the
//   following IDLE cycle. Priority: loader > starved fetch > data > fetch.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic reset,
  ram_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic en_q, starved, w_we;
  logic [1:0] win;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  always_comb begin
    starved = wait_cnt >= WMAX;
    win = bus.ld_req ? 2'd3 : (bus.if_req && starved) ? 2'd1 : bus.dt_req ? 2'd2 :
          bus.if_req ? 2'd1 : 2'd0;
    w_we = win == 2'd3 ? bus.ld_we : win == 2'd2 ? bus.dt_we : 1'b0;
    w_addr = win == 2'd3 ? bus.ld_addr : win == 2'd2 ? bus.dt_addr : bus.if_addr;
    w_wdata = win == 2'd3 ? bus.ld_wdata : win == 2'd2 ? bus.dt_wdata : '0;
  end
  // Masking with reset keeps a write that is in ISSUE when reset arrives from committing.
  assign bus.ram_en = en_q & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      en_q <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.busy <= 1'b0;
      bus.owner <= 2'd0;
      bus.ld_ack <= 1'b0;
      bus.dt_ack <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.ld_rdata <= '0;
      bus.dt_rdata <= '0;
      bus.if_rdata <= '0;
    end else begin
      bus.ld_ack <= 1'b0;
      bus.dt_ack <= 1'b0;
      bus.if_ack <= 1'b0;
      case (state)
        IDLE: begin
          bus.owner <= win;
          if (win != 2'd0) begin
            state <= ISSUE;
            en_q <= 1'b1;
            bus.busy <= 1'b1;
            bus.ram_we <= w_we;
            bus.ram_addr <= w_addr;
            bus.ram_wdata <= w_wdata;
            wait_cnt <= win == 2'd1 ? '0 : (bus.if_req && !starved) ? wait_cnt + CW'(1) : wait_cnt;
          end
        end
        ISSUE: begin
          state <= RESP;
          en_q <= 1'b0;
          bus.ram_we <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          if (bus.owner == 2'd3) begin
            bus.ld_ack <= 1'b1;
            bus.ld_rdata <= bus.ram_rdata;
          end
          if (bus.owner == 2'd2) begin
            bus.dt_ack <= 1'b1;
            bus.dt_rdata <= bus.ram_rdata;
          end
          if (bus.owner == 2'd1) begin
            bus.if_ack <= 1'b1;
            bus.if_rdata <= bus.ram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench with a transaction-level arbiter/RAM model and a behavioural RAM
module tb_ram_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ram_arbiter_if bus();
  ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    int port;
    logic [15:0] data;
    bit we;
    int due;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_new, m_e;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int free_in = 0;
  int wcnt = 0;
  bit has_pend = 0;
  int p_port;
  bit p_we;
  logic [7:0] p_addr;
  logic [15:0] p_wdata;
  int m_na, m_port;
  logic [15:0] m_rd;
  function automatic logic [15:0] init_val(int i);
    return 16'(i * 257) ^ 16'hA5C3;
  endfunction
  function automatic bit ack_of(int p);
    return p == 3 ? bus.ld_ack : p == 2 ? bus.dt_ack : bus.if_ack;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // plain synchronous RAM: write and registered read on an enabled edge
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  // reference: an access is granted when the arbiter is free, completes one edge later
  // (memory read/updated then) and its ack is due one edge after that
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      free_in = 0;
      wcnt = 0;
      has_pend = 0;
      exp_q.delete();
    end else begin
      if (has_pend) begin
        e_new.port = p_port;
        e_new.data = ref_mem[p_addr];
        e_new.we = p_we;
        e_new.due = cyc + 1;
        exp_q.push_back(e_new);
        if (p_we) ref_mem[p_addr] = p_wdata;
        has_pend = 0;
      end
      if (free_in > 0) free_in--;
      else if (bus.ld_req || bus.dt_req || bus.if_req) begin
        if (bus.ld_req) begin
          p_port = 3; p_we = bus.ld_we; p_addr = bus.ld_addr; p_wdata = bus.ld_wdata;
        end else if (bus.dt_req && !(bus.if_req && wcnt >= MAX_WAIT)) begin
          p_port = 2; p_we = bus.dt_we; p_addr = bus.dt_addr; p_wdata = bus.dt_wdata;
        end else begin
          p_port = 1; p_we = 0; p_addr = bus.if_addr; p_wdata = 16'h0;
        end
        wcnt = p_port == 1 ? 0 : bus.if_req ? (wcnt < MAX_WAIT ? wcnt + 1 : MAX_WAIT) : wcnt;
        has_pend = 1;
        free_in = 2;
      end
    end
  end
  // monitor: every ack is matched against the oldest expected response
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      m_na = int'(bus.ld_ack) + int'(bus.dt_ack) + int'(bus.if_ack);
      if (m_na > 0) begin
        chk("ack_single", m_na, 1);
        m_port = bus.ld_ack ? 3 : bus.dt_ack ? 2 : 1;
        m_rd = bus.ld_ack ? bus.ld_rdata : bus.dt_ack ? bus.dt_rdata : bus.if_rdata;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: port %0d acked, none expected (cycle %0d)", m_port, cyc);
        end else begin
          m_e = exp_q.pop_front();
          chk("ack_port", m_port, m_e.port);
          chk("ack_cycle", cyc, m_e.due);
          if (!m_e.we) chk("ack_rdata", m_rd, m_e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        m_e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_ack: port %0d ack absent, required at cycle %0d", m_e.port, m_e.due);
      end
    end
  end
  task automatic wait_ack(input int port);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ack_of(port) && n < 400);
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack, required within 400 cycles", port);
    end
  endtask
  task automatic do_ld(input bit we, input logic [7:0] a, input logic [15:0] d);
    bus.ld_req = 1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
    wait_ack(3);
    bus.ld_req = 0;
  endtask
  task automatic do_dt(input bit we, input logic [7:0] a, input logic [15:0] d);
    bus.dt_req = 1; bus.dt_we = we; bus.dt_addr = a; bus.dt_wdata = d;
    wait_ack(2);
    bus.dt_req = 0;
  endtask
  task automatic do_if(input logic [7:0] a);
    bus.if_req = 1; bus.if_addr = a;
    wait_ack(1);
    bus.if_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
    bus.dt_req = 0; bus.dt_we = 0; bus.dt_addr = 0; bus.dt_wdata = 0;
    bus.if_req = 0; bus.if_addr = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_ld_ack", bus.ld_ack, 0);
    chk("rst_dt_ack", bus.dt_ack, 0);
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_ld_rdata", bus.ld_rdata, 0);
    chk("rst_dt_rdata", bus.dt_rdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 8'h00; bus.ld_wdata = 16'h4001;
    tick();
    chk("ld_issue_en", bus.ram_en, 1);
    chk("ld_issue_we", bus.ram_we, 1);
    chk("ld_issue_addr", bus.ram_addr, 8'h00);
    chk("ld_issue_wdata", bus.ram_wdata, 16'h4001);
    chk("ld_issue_owner", bus.owner, 3);
    chk("ld_issue_busy", bus.busy, 1);
    tick();
    chk("ld_resp_en", bus.ram_en, 0);
    chk("ld_resp_ack", bus.ld_ack, 0);
    tick();
    chk("ld_ack_pulse", bus.ld_ack, 1);
    bus.ld_req = 0;
    tick();
    chk("ld_ack_drop", bus.ld_ack, 0);
    chk("ld_owner_clear", bus.owner, 0);
    bus.if_req = 1; bus.if_addr = 8'h00;
    tick();
    chk("if_issue_we", bus.ram_we, 0);
    chk("if_issue_owner", bus.owner, 1);
    repeat (2) tick();
    chk("if_ack_pulse", bus.if_ack, 1);
    chk("if_rdata", bus.if_rdata, 16'h4001);
    bus.if_req = 0;
    tick();
    fork
      do_dt(0, 8'h05, 16'h0);
      do_if(8'h02);
      begin
        tick();
        chk("both_first_owner", bus.owner, 2);
        repeat (3) tick();
        chk("both_second_owner", bus.owner, 1);
      end
    join
    tick();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus.dt_req = 1; bus.dt_we = 0; bus.dt_addr = 8'(8'h30 + i);
          wait_ack(2);
        end
        bus.dt_req = 0;
      end
      do_if(8'h40);
      begin
        int dc = 0;
        int k = 0;
        while (!bus.if_ack && k < 200) begin
          tick();
          if (bus.dt_ack) dc++;
          k++;
        end
        chk("starve_losses", dc, MAX_WAIT);
        chk("starve_wait_clear", 32'(dut.wait_cnt), 0);
      end
    join
    repeat (2) tick();
    fork
      do_ld(0, 8'h10, 16'h0);
      do_dt(0, 8'h11, 16'h0);
      do_if(8'h12);
      begin
        int seq[$];
        int tms[$];
        int k = 0;
        while (seq.size() < 3 && k < 60) begin
          tick();
          k++;
          if (bus.ld_ack || bus.dt_ack || bus.if_ack) begin
            seq.push_back(bus.ld_ack ? 3 : bus.dt_ack ? 2 : 1);
            tms.push_back(cyc);
          end
        end
        chk("all3_count", seq.size(), 3);
        if (seq.size() == 3) begin
          chk("all3_first", seq[0], 3);
          chk("all3_second", seq[1], 2);
          chk("all3_third", seq[2], 1);
          chk("all3_gap1", tms[1] - tms[0], 3);
          chk("all3_gap2", tms[2] - tms[1], 3);
        end
      end
    join
    tick();
    bus.dt_req = 1; bus.dt_we = 1; bus.dt_addr = 8'h20; bus.dt_wdata = 16'hBEEF;
    tick();
    chk("rstmid_issue_en", bus.ram_en, 1);
    reset = 1;
    tick();
    chk("rstmid_en_off", bus.ram_en, 0);
    chk("rstmid_no_ack", bus.dt_ack, 0);
    chk("rstmid_busy", bus.busy, 0);
    bus.dt_req = 0; bus.dt_we = 0;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmid_no_stale_ack", bus.dt_ack, 0);
    end
    do_ld(0, 8'h20, 16'h0);
    chk("rstmid_not_committed", bus.ld_rdata, init_val(32));
    tick();
    bus.dt_req = 1; bus.dt_we = 0; bus.dt_addr = 8'h05;
    tick();
    bus.dt_req = 0;
    repeat (2) tick();
    chk("drop_ack", bus.dt_ack, 1);
    chk("drop_rdata", bus.dt_rdata, init_val(5));
    tick();
    chk("drop_owner_clear", bus.owner, 0);
    chk("drop_busy", bus.busy, 0);
    chk("drop_ack_clear", bus.dt_ack, 0);
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        do_ld(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        do_dt(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        do_if(8'($urandom_range(0, 15)));
      end
    join
    repeat (10) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
